// File: rtl/pipe_hazard_ctrl_pkg.sv
// ============================================================================
// Module   : pipe_hazard_ctrl_pkg
// Brief    : Shared types and constants for the pipeline hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_hazard_ctrl_pkg;

    localparam int REG_ADDRESS_LENGTH = 5;
    localparam int FWD_REGFILE        = 0;

    typedef struct packed {
        logic                          valid;
        logic                          wr_en;
        logic [REG_ADDRESS_LENGTH-1:0] rd;
        logic                          is_load;
    } stage_entry_t;

    // Returns at least 1 so a select bus never collapses to zero width.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hazard_match.sv
// ============================================================================
// Module   : hazard_match
// Brief    : Per-operand priority compare over the in-flight entries; the
//            youngest matching producer wins. Honours R0_ZERO_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_match
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int SEL_W = 2
) (
    input  stage_entry_t [DEPTH:1]          entries,
    input  logic [REG_ADDRESS_LENGTH-1:0]   addr,
    input  logic                            used,
    output logic [SEL_W-1:0]                sel,
    output logic                            is_load
);

    logic w_addr_ok;

`ifdef R0_ZERO_EN
    assign w_addr_ok = used && (addr != '0);
`else
    assign w_addr_ok = used;
`endif

    // Scan oldest to youngest so the last hit is the smallest index.
    always_comb begin
        sel     = SEL_W'(FWD_REGFILE);
        is_load = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (w_addr_ok && entries[k].valid && entries[k].wr_en &&
                (entries[k].rd == addr)) begin
                sel     = SEL_W'(k);
                is_load = entries[k].is_load;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Hazard/forwarding controller: forward selects, load-use stall,
//            dmem-wait freeze, branch-shadow flush. Option: R0_ZERO_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int DEPTH            = 2,
    parameter int LOAD_READY_STAGE = 2,
    parameter int BRANCH_SHADOW    = 1,
    parameter int COUNT_WIDTH      = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              id_valid,
    input  logic [REG_ADDRESS_LENGTH-1:0]     id_ra,
    input  logic [REG_ADDRESS_LENGTH-1:0]     id_rb,
    input  logic                              id_ra_used,
    input  logic                              id_rb_used,
    input  logic [REG_ADDRESS_LENGTH-1:0]     id_rd,
    input  logic                              id_wr_en,
    input  logic                              id_is_load,
    input  logic                              branch_taken,
    input  logic                              dmem_ready,
    output logic [clog2(DEPTH+1)-1:0]         fwd_sel_a,
    output logic [clog2(DEPTH+1)-1:0]         fwd_sel_b,
    output logic                              stall,
    output logic                              freeze,
    output logic                              flush_if,
    output logic [COUNT_WIDTH-1:0]            stall_count,
    output logic [COUNT_WIDTH-1:0]            flush_count
);

    localparam int c_SEL_W = clog2(DEPTH + 1);

    stage_entry_t [DEPTH:1]     r_entry;
    logic [2:0]                 r_flush_cnt;
    logic                       r_pending;
    logic [COUNT_WIDTH-1:0]     r_stall_cnt;
    logic [COUNT_WIDTH-1:0]     r_flush_total;

    logic [c_SEL_W-1:0]         w_sel_a;
    logic [c_SEL_W-1:0]         w_sel_b;
    logic                       w_ld_a;
    logic                       w_ld_b;
    logic                       w_freeze;
    logic                       w_load_use;
    logic                       w_branch_acc;
    logic                       w_stall;
    logic                       w_flush_if;
    stage_entry_t               w_new;

    hazard_match #(.DEPTH(DEPTH), .SEL_W(c_SEL_W)) u_match_a (
        .entries (r_entry),
        .addr    (id_ra),
        .used    (id_ra_used),
        .sel     (w_sel_a),
        .is_load (w_ld_a)
    );

    hazard_match #(.DEPTH(DEPTH), .SEL_W(c_SEL_W)) u_match_b (
        .entries (r_entry),
        .addr    (id_rb),
        .used    (id_rb_used),
        .sel     (w_sel_b),
        .is_load (w_ld_b)
    );

    assign w_freeze   = r_entry[1].valid && r_entry[1].is_load && !dmem_ready;
    assign w_load_use = (w_ld_a && (w_sel_a != '0) && (32'(w_sel_a) < LOAD_READY_STAGE)) ||
                        (w_ld_b && (w_sel_b != '0) && (32'(w_sel_b) < LOAD_READY_STAGE));

    // A branch seen while frozen is held back and surfaces on the first free cycle.
    assign w_branch_acc = (branch_taken || r_pending) && !w_freeze;
    assign w_flush_if   = (r_flush_cnt != '0) || w_branch_acc;
    assign w_stall      = w_freeze || (w_load_use && !w_branch_acc);

    always_comb begin
        w_new.valid   = id_valid;
        w_new.rd      = id_rd;
        w_new.is_load = id_is_load;
`ifdef R0_ZERO_EN
        w_new.wr_en   = id_wr_en && (id_rd != '0);
`else
        w_new.wr_en   = id_wr_en;
`endif
        if (w_stall || w_flush_if || !id_valid) begin
            w_new = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_entry       <= '0;
            r_flush_cnt   <= '0;
            r_pending     <= 1'b0;
            r_stall_cnt   <= '0;
            r_flush_total <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_branch_acc && (r_flush_total != '1)) begin
                r_flush_total <= r_flush_total + 1'b1;
            end
            if (w_freeze) begin
                r_pending <= r_pending || branch_taken;
            end else begin
                r_pending <= 1'b0;
                r_entry[1] <= w_new;
                for (int k = 2; k <= DEPTH; k++) begin
                    r_entry[k] <= r_entry[k-1];
                end
                if (w_branch_acc) begin
                    r_flush_cnt <= 3'(BRANCH_SHADOW);
                end else if (r_flush_cnt != '0) begin
                    r_flush_cnt <= r_flush_cnt - 1'b1;
                end
            end
        end
    end

    assign fwd_sel_a   = w_sel_a;
    assign fwd_sel_b   = w_sel_b;
    assign stall       = w_stall;
    assign freeze      = w_freeze;
    assign flush_if    = w_flush_if;
    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_total;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Directed self-checking bench for pipe_hazard_ctrl (DEPTH=2,
//            LOAD_READY_STAGE=2, BRANCH_SHADOW=2). Honours R0_ZERO_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_ra;
    logic [4:0]  id_rb;
    logic        id_ra_used;
    logic        id_rb_used;
    logic [4:0]  id_rd;
    logic        id_wr_en;
    logic        id_is_load;
    logic        branch_taken;
    logic        dmem_ready;
    logic [1:0]  fwd_sel_a;
    logic [1:0]  fwd_sel_b;
    logic        stall;
    logic        freeze;
    logic        flush_if;
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    int n_vec;
    int n_err;

    pipe_hazard_ctrl #(
        .DEPTH            (2),
        .LOAD_READY_STAGE (2),
        .BRANCH_SHADOW    (2),
        .COUNT_WIDTH      (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_ra        (id_ra),
        .id_rb        (id_rb),
        .id_ra_used   (id_ra_used),
        .id_rb_used   (id_rb_used),
        .id_rd        (id_rd),
        .id_wr_en     (id_wr_en),
        .id_is_load   (id_is_load),
        .branch_taken (branch_taken),
        .dmem_ready   (dmem_ready),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .stall        (stall),
        .freeze       (freeze),
        .flush_if     (flush_if),
        .stall_count  (stall_count),
        .flush_count  (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] ra, input logic rau,
                          input logic [4:0] rb, input logic rbu,
                          input logic [4:0] rd, input logic wr, input logic ld);
        id_valid   = v;
        id_ra      = ra;
        id_ra_used = rau;
        id_rb      = rb;
        id_rb_used = rbu;
        id_rd      = rd;
        id_wr_en   = wr;
        id_is_load = ld;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        branch_taken = 1'b0;
        dmem_ready = 1'b1;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({fwd_sel_a, fwd_sel_b, stall, freeze, flush_if} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 0000000", {fwd_sel_a, fwd_sel_b, stall, freeze, flush_if});
        end
        n_vec++;
        if ((stall_count !== 32'd0) || (flush_count !== 32'd0)) begin
            n_err++;
            $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_count, flush_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        n_vec++;
        if ((fwd_sel_a !== 2'd1) || (stall !== 1'b0)) begin
            n_err++;
            $display("FAIL b2b_fwd1: sel_a=%0d stall=%b want 1/0", fwd_sel_a, stall);
        end
        tick();
        set_id(1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0);
        n_vec++;
        if ((fwd_sel_a !== 2'd2) || (fwd_sel_b !== 2'd1)) begin
            n_err++;
            $display("FAIL b2b_fwd2: sel_a=%0d sel_b=%0d want 2/1", fwd_sel_a, fwd_sel_b);
        end
        tick();
        set_id(1'b1, 5'd9, 1'b1, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0);
        tick();
        // both entries now hold rd=9; the younger must be chosen, unused rb ignored
        set_id(1'b1, 5'd9, 1'b1, 5'd9, 1'b0, 5'd1, 1'b0, 1'b0);
        n_vec++;
        if ((fwd_sel_a !== 2'd1) || (fwd_sel_b !== 2'd0)) begin
            n_err++;
            $display("FAIL youngest_wins: sel_a=%0d sel_b=%0d want 1/0", fwd_sel_a, fwd_sel_b);
        end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
        n_vec++;
        if ((stall !== 1'b1) || (fwd_sel_b !== 2'd1)) begin
            n_err++;
            $display("FAIL load_use_stall: stall=%b sel_b=%0d want 1/1", stall, fwd_sel_b);
        end
        tick();
        n_vec++;
        if ((stall !== 1'b0) || (fwd_sel_b !== 2'd2) || (stall_count !== 32'd1)) begin
            n_err++;
            $display("FAIL load_use_release: stall=%b sel_b=%0d cnt=%0d want 0/2/1", stall, fwd_sel_b, stall_count);
        end
        tick();
    endtask

    task automatic test_dmem_wait();
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
        dmem_ready = 1'b0;
        tick();
        set_id(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ((freeze !== 1'b1) || (stall !== 1'b1) || (fwd_sel_a !== 2'd1)) begin
                n_err++;
                $display("FAIL dmem_freeze[%0d]: freeze=%b stall=%b sel_a=%0d want 1/1/1", i, freeze, stall, fwd_sel_a);
            end
            tick();
        end
        dmem_ready = 1'b1;
        #1;
        n_vec++;
        if ((freeze !== 1'b0) || (stall !== 1'b1)) begin
            n_err++;
            $display("FAIL dmem_ready_cycle: freeze=%b stall=%b want 0/1", freeze, stall);
        end
        tick();
        n_vec++;
        if ((fwd_sel_a !== 2'd2) || (stall !== 1'b0) || (stall_count !== 32'd4)) begin
            n_err++;
            $display("FAIL dmem_shift: sel_a=%0d stall=%b cnt=%0d want 2/0/4", fwd_sel_a, stall, stall_count);
        end
        tick();
    endtask

    task automatic test_branch();
        logic [3:0] exp_fl;
        logic [3:0] got_fl;
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
        branch_taken = 1'b1;
        #1;
        got_fl[3] = flush_if;
        tick();
        branch_taken = 1'b0;
        set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        n_vec++;
        if (fwd_sel_a !== 2'd0) begin
            n_err++;
            $display("FAIL branch_bubble: sel_a=%0d want 0", fwd_sel_a);
        end
        got_fl[2] = flush_if;
        tick();
        got_fl[1] = flush_if;
        tick();
        got_fl[0] = flush_if;
        exp_fl = 4'b1110;
        n_vec++;
        if ((got_fl !== exp_fl) || (flush_count !== 32'd1)) begin
            n_err++;
            $display("FAIL branch_shadow: flush=%b cnt=%0d want 1110/1", got_fl, flush_count);
        end
        // branch arriving while a load waits on dmem
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        dmem_ready = 1'b0;
        branch_taken = 1'b1;
        #1;
        got_fl[3] = flush_if;
        tick();
        branch_taken = 1'b0;
        #1;
        got_fl[2] = flush_if;
        dmem_ready = 1'b1;
        #1;
        got_fl[1] = flush_if;
        tick();
        got_fl[0] = flush_if;
        exp_fl = 4'b0011;
        n_vec++;
        if ((got_fl !== exp_fl) || (flush_count !== 32'd2)) begin
            n_err++;
            $display("FAIL branch_in_freeze: flush=%b cnt=%0d want 0011/2", got_fl, flush_count);
        end
        tick();
        tick();
        n_vec++;
        if (flush_if !== 1'b0) begin
            n_err++;
            $display("FAIL branch_in_freeze_end: flush=%b want 0", flush_if);
        end
        // branch coinciding with a load-use hazard
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        branch_taken = 1'b1;
        #1;
        n_vec++;
        if ((stall !== 1'b0) || (flush_if !== 1'b1)) begin
            n_err++;
            $display("FAIL branch_vs_load_use: stall=%b flush=%b want 0/1", stall, flush_if);
        end
        tick();
        branch_taken = 1'b0;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_r0();
        logic [1:0] exp_sel;
`ifdef R0_ZERO_EN
        exp_sel = 2'd0;
`else
        exp_sel = 2'd1;
`endif
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0);
        n_vec++;
        if ((fwd_sel_a !== exp_sel) || (stall !== exp_sel[0])) begin
            n_err++;
            $display("FAIL r0_forward: sel_a=%0d stall=%b want %0d/%b", fwd_sel_a, stall, exp_sel, exp_sel[0]);
        end
        tick();
    endtask

    task automatic test_reset_mid_freeze();
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        dmem_ready = 1'b0;
        branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        n_vec++;
        if ({stall, freeze, flush_if} !== 3'b000 || (stall_count !== 32'd0) || (flush_count !== 32'd0)) begin
            n_err++;
            $display("FAIL reset_mid_freeze: s/f/fl=%b cnt=%0d/%0d want 000 0/0", {stall, freeze, flush_if}, stall_count, flush_count);
        end
        dmem_ready = 1'b1;
        tick();
        n_vec++;
        if ((flush_if !== 1'b0) || (flush_count !== 32'd0)) begin
            n_err++;
            $display("FAIL reset_no_pending: flush=%b cnt=%0d want 0/0", flush_if, flush_count);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_back_to_back();
        test_load_use();
        test_dmem_wait();
        test_branch();
        test_r0();
        test_reset_mid_freeze();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
